// File: rtl/serial_tx.sv
// ----------------------------------------------------------------------------
// serial_tx -- frame-based serial transmitter (start bit, DATA_W data bits
// LSB first, one stop bit), each bit held for CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   DATA_W        payload bits per frame
//
// Ports
//   clk       single clock, rising edge
//   REST      asynchronous active-low reset
//   tx_data   parallel payload, captured on the accept edge only
//   tx_valid  producer has a word on tx_data
//   tx_ready  block can accept a word this cycle (registered, high in IDLE)
//   tx_out    serial line, idles high (registered)
//   busy      frame in progress, complement of tx_ready (registered)
// ----------------------------------------------------------------------------
module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              REST,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              bit_done;

    // Last cycle of the current serial bit.
    assign bit_done = (cyc_cnt == CNT_LAST);

    // NOTE: every register below uses non-blocking assignments so all of
    // them update together from the values present before the edge.
    always_ff @(posedge clk or negedge REST) begin
        if (!REST) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            // NOTE: the shift register is reset as well; it is a handful of
            // flops, not a memory, and a clean value eases debug.
            shift_reg <= '0;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Counters hold while idle; only a handshake moves us on.
                    if (tx_valid && tx_ready) begin
                        state     <= START;
                        shift_reg <= tx_data;
                        cyc_cnt   <= '0;
                        tx_out    <= 1'b0;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (bit_done) begin
                        state     <= DATA;
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                        tx_out    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end else begin
                            // Shift register always presents the next bit at [0].
                            bit_cnt   <= bit_cnt + 1'b1;
                            tx_out    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        state    <= IDLE;
                        cyc_cnt  <= '0;
                        tx_out   <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                default: begin
                    // Unreachable encodings fall back to a quiet idle line.
                    state    <= IDLE;
                    cyc_cnt  <= '0;
                    bit_cnt  <= '0;
                    tx_out   <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_serial_tx -- self-checking bench for serial_tx (CLKS_PER_BIT=4, DATA_W=8).
// A reference model describes the line as a function of the number of cycles
// elapsed since the accepting edge: frame bit n = cycles / CLKS_PER_BIT, where
// bit 0 is the start bit, bits 1..DATA_W carry the payload LSB first and the
// last bit is the stop bit.
// ----------------------------------------------------------------------------
module tb_serial_tx;

    localparam int CPB       = 4;
    localparam int DW        = 8;
    localparam int FRAME_CYC = (2 + DW) * CPB;

    logic          clk      = 1'b0;
    logic          REST     = 1'b1;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_out;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since the accepting edge, -1 while idle.
    int            m_pos  = -1;
    logic [DW-1:0] m_word = '0;

    serial_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW)
    ) dut (
        .clk     (clk),
        .REST    (REST),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out  (tx_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic exp_line();
        int idx;
        if (m_pos < 0) return 1'b1;
        idx = m_pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return m_word[idx-1];
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "/tx_out"},   {31'd0, tx_out},   {31'd0, exp_line()});
        check({tag, "/tx_ready"}, {31'd0, tx_ready}, {31'd0, (m_pos < 0)});
        check({tag, "/busy"},     {31'd0, busy},     {31'd0, (m_pos >= 0)});
    endtask

    // One clock: advance the model on the edge, then compare 1 ns later.
    task automatic step();
        @(posedge clk);
        if (!REST) begin
            m_pos = -1;
        end else if (m_pos < 0) begin
            if (tx_valid) begin
                m_pos  = 0;
                m_word = tx_data;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME_CYC) m_pos = -1;
        end
        #1;
        check_outputs("cyc");
    endtask

    // Assert reset between edges and confirm the outputs react immediately.
    task automatic async_reset(input string tag);
        #2;
        REST  = 1'b0;
        m_pos = -1;
        #1;
        check_outputs(tag);
    endtask

    // Offer word d for one cycle and watch 45 cycles. Optionally pulse
    // tx_valid with new data at cycle pulse_at while the frame is in flight.
    task automatic send_and_capture(input logic [DW-1:0] d, input int pulse_at,
                                    output logic [DW+1:0] bits, output int low);
        bits     = '0;
        low      = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int j = 0; j < FRAME_CYC + 5; j++) begin
            step();
            if (!tx_ready) low++;
            if (j < FRAME_CYC && (j % CPB) == 2) bits[j/CPB] = tx_out;
            tx_valid = (j + 1 == pulse_at);
            if (j + 1 == pulse_at) tx_data = 8'h3C;
        end
    endtask

    logic [DW+1:0] bits;
    logic [DW+1:0] exp_bits;
    int            low;
    int            mism;

    initial begin
        // Asynchronous reset well before the first rising edge (t=5).
        #3;
        REST  = 1'b0;
        m_pos = -1;
        #1;
        check("rst_tx_out",   {31'd0, tx_out},   32'd1);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);

        // Requests during reset are ignored.
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        step();
        step();
        tx_valid = 1'b0;
        REST     = 1'b1;

        // Stability: 100 idle cycles.
        for (int i = 0; i < 100; i++) step();

        // Single frame 0xA5.
        send_and_capture(8'hA5, -1, bits, low);
        exp_bits = 10'b1101001010;
        check("a5_line", {22'd0, bits}, {22'd0, exp_bits});
        check("a5_ready_low", low, 40);

        // Back-to-back 0x00 then 0xFF with tx_valid held high.
        mism     = 0;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        for (int j = 0; j < 2 * FRAME_CYC + 5; j++) begin
            logic want;
            step();
            if (j == 0) tx_data = 8'hFF;
            if (j == FRAME_CYC + 1) tx_valid = 1'b0;
            if (j < 36)       want = 1'b0;
            else if (j < 41)  want = 1'b1;
            else if (j < 45)  want = 1'b0;
            else              want = 1'b1;
            if (tx_out !== want) mism++;
        end
        check("b2b_runs", mism, 0);

        // Ignored request mid-frame: valid pulse with 0x3C during 0x81.
        send_and_capture(8'h81, 10, bits, low);
        exp_bits = 10'b1100000010;
        check("ign_line", {22'd0, bits}, {22'd0, exp_bits});
        check("ign_ready_low", low, 40);

        // Mid-frame reset during data bit 3 of 0xF0.
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int j = 1; j < 18; j++) step();
        async_reset("mid_rst");
        check("mid_rst_line", {31'd0, tx_out}, 32'd1);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int i = 0; i < 3; i++) step();
        REST = 1'b1;
        send_and_capture(8'h55, -1, bits, low);
        exp_bits = 10'b1010101010;
        check("rst55_line", {22'd0, bits}, {22'd0, exp_bits});
        check("rst55_ready_low", low, 40);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = DW'($urandom);
            step();
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd_rst");
                step();
                REST = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
